// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// The MC_ADDI_EN build option enables the addi states; the state width is 4 bits in both builds.
`timescale 1ns/1ps
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       illegal_op;
    logic       mem_err;
  } ctrl_t;

  // States that wait on the memory handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory stall counter: counts stalled cycles and flags the cycle on which
// the count has reached MEM_TIMEOUT while still stalled (MEM_TIMEOUT = 0 disables).
`timescale 1ns/1ps
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_stall_en,
  output logic o_timeout
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] r_count;

  // Stall counter; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_stall_en) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_timeout = (MEM_TIMEOUT > 0) && i_stall_en && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (Moore decodes plus
// mem_ready / opcode qualifiers). Define MC_ADDI_EN to add the addi states.
`timescale 1ns/1ps
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next;
  logic   r_is_sw;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;
  logic   w_stall;
  logic   w_timeout;
  logic   w_clear;

  assign w_stall = is_wait_state(r_state) && !mem_ready;
  // A timeout leaves the wait (even FETCH -> FETCH), so the count restarts.
  assign w_clear = !w_stall || w_timeout;

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_stall_en (w_stall),
    .o_timeout  (w_timeout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // lw/sw choice is captured in DECODE since opcode is only valid there.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_sw <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_sw <= (opcode == OP_SW);
    end else begin
      r_is_sw <= r_is_sw;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_src    = PCSRC_ALU;
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_next          = S_DECODE;
        end else if (w_timeout) begin
          w_ctrl.mem_err = 1'b1;
          w_next         = S_FETCH;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
        w_ctrl.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      w_next = S_ADDIEX;
`endif
          default: begin
            w_ctrl.illegal_op = 1'b1;
            w_next            = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        if (r_is_sw) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          w_ctrl.mem_err = 1'b1;
          w_next         = S_FETCH;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_ctrl.mem_err = 1'b1;
          w_next         = S_FETCH;
        end else begin
          w_next = S_MEMWR;
        end
      end
      S_EXECUTE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_op    = ALUOP_FUNCT;
        w_next           = S_ALUWB;
      end
      S_ALUWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
        w_next            = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_B;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_src        = PCSRC_ALUOUT;
        w_ctrl.pc_write_cond = 1'b1;
        w_next               = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pc_src   = PCSRC_JUMP;
        w_ctrl.pc_write = 1'b1;
        w_next          = S_FETCH;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_next           = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b0;
        w_next            = S_FETCH;
      end
`endif
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Reset forces every control low in the same cycle so no partial write escapes.
  always_comb begin
    if (reset) begin
      w_out = '0;
    end else begin
      w_out = w_ctrl;
    end
  end

  assign IorD        = w_out.iord;
  assign MemRead     = w_out.mem_read;
  assign MemWrite    = w_out.mem_write;
  assign IRWrite     = w_out.ir_write;
  assign RegDst      = w_out.reg_dst;
  assign MemtoReg    = w_out.mem_to_reg;
  assign RegWrite    = w_out.reg_write;
  assign ALUSrcA     = w_out.alu_src_a;
  assign ALUSrcB     = w_out.alu_src_b;
  assign ALUOp       = w_out.alu_op;
  assign PCSrc       = w_out.pc_src;
  assign PCWrite     = w_out.pc_write;
  assign PCWriteCond = w_out.pc_write_cond;
  assign illegal_op  = w_out.illegal_op;
  assign mem_err     = w_out.mem_err;
  assign state       = r_state;

endmodule
